// File: rtl/signed_mult_accum.sv
// signed_mult_accum: signed multiply-accumulate datapath for the convolution engine.
// Multiplies pixel sample x by kernel coefficient y each falling edge and adds the
// product into a wrapping ACC_W-bit running sum presented on LocalReg.
module signed_mult_accum #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter bit X_SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              AccumReset,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [ACC_W-1:0]  LocalReg
);

  // One guard bit on x lets a single signed multiplier cover both the
  // two's-complement and the zero-extended pixel formats.
  localparam int PROD_W = 2 * DATA_W;
  localparam int MUL_W  = PROD_W + 1;

  logic signed [DATA_W:0]   xExt;
  logic signed [DATA_W-1:0] ySgn;
  logic signed [MUL_W-1:0]  xWide;
  logic signed [MUL_W-1:0]  yWide;
  logic signed [MUL_W-1:0]  prodFull;
  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0]  prodAcc;
  logic        [ACC_W-1:0]  acc_q;
  logic        [ACC_W-1:0]  acc_d;

  // Form the full-width signed product; it always fits in 2*DATA_W bits,
  // then sign-extend it to the accumulator width.
  always_comb begin
    xExt     = X_SIGNED ? {x[DATA_W-1], x} : {1'b0, x};
    ySgn     = $signed(y);
    xWide    = MUL_W'(xExt);
    yWide    = MUL_W'(ySgn);
    prodFull = xWide * yWide;
    prod     = prodFull[PROD_W-1:0];
    prodAcc  = ACC_W'(prod);
    acc_d    = acc_q + prodAcc;
  end

  // Accumulate on every falling edge; a reset edge clears the sum and drops the product.
  always_ff @(negedge clk) begin
    if (AccumReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign LocalReg = acc_q;

endmodule

// File: tb/tb_signed_mult_accum.sv
// tb_signed_mult_accum: randomized and directed checks of signed_mult_accum against
// an arithmetic reference model, for signed-x, unsigned-x and 16-bit variants.
module tb_signed_mult_accum;

  logic        clk;
  logic        rstS, rstU, rstW;
  logic [7:0]  xS, yS, xU, yU;
  logic [15:0] xW, yW;
  logic [31:0] regS, regU, regW;

  int total;
  int bad;

  logic [31:0] model [3];

  signed_mult_accum #(.DATA_W(8), .ACC_W(32), .X_SIGNED(1'b1)) dutS (
    .clk(clk), .AccumReset(rstS), .x(xS), .y(yS), .LocalReg(regS)
  );

  signed_mult_accum #(.DATA_W(8), .ACC_W(32), .X_SIGNED(1'b0)) dutU (
    .clk(clk), .AccumReset(rstU), .x(xU), .y(yU), .LocalReg(regU)
  );

  signed_mult_accum #(.DATA_W(16), .ACC_W(32), .X_SIGNED(1'b1)) dutW (
    .clk(clk), .AccumReset(rstW), .x(xW), .y(yW), .LocalReg(regW)
  );

  // Free-running clock; the DUT acts on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint asSigned8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return longint'(t);
  endfunction

  function automatic longint asUnsigned8(input int v);
    logic [7:0] t;
    t = v[7:0];
    return longint'(t);
  endfunction

  function automatic longint asSigned16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h (%0d) expected=0x%08h (%0d)",
               tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // Drive one pair into the selected instance (0 signed, 1 unsigned-x, 2 wide);
  // the other two are held in reset. Then check all three against the model.
  task automatic applyStimulus(input int which, input logic r, input int xa, input int ya);
    longint p;
    @(posedge clk);
    rstS = 1'b1; xS = '0; yS = '0;
    rstU = 1'b1; xU = '0; yU = '0;
    rstW = 1'b1; xW = '0; yW = '0;
    case (which)
      0: begin rstS = r; xS = xa[7:0];  yS = ya[7:0];  end
      1: begin rstU = r; xU = xa[7:0];  yU = ya[7:0];  end
      default: begin rstW = r; xW = xa[15:0]; yW = ya[15:0]; end
    endcase
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != which || r) begin
        model[i] = 32'd0;
      end else begin
        if (i == 0)      p = asSigned8(xa) * asSigned8(ya);
        else if (i == 1) p = asUnsigned8(xa) * asSigned8(ya);
        else             p = asSigned16(xa) * asSigned16(ya);
        model[i] = model[i] + 32'(p);
      end
    end
    checkOutput("model_signed",   regS, model[0]);
    checkOutput("model_unsigned", regU, model[1]);
    checkOutput("model_wide",     regW, model[2]);
  endtask

  int sharpX [9] = '{10, 10, 10, 10, 20, 10, 10, 10, 10};
  int sharpY [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

  initial begin
    int which, len, rv;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) model[i] = 32'd0;
    rstS = 1'b1; xS = '0; yS = '0;
    rstU = 1'b1; xU = '0; yU = '0;
    rstW = 1'b1; xW = '0; yW = '0;

    // Reset, then accumulate on the signed instance
    applyStimulus(0, 1'b1, 0, 0);
    checkOutput("reset_signed", regS, 32'd0);
    checkOutput("reset_unsigned", regU, 32'd0);
    applyStimulus(0, 1'b0, 3, 4);
    checkOutput("acc_3x4", regS, 32'd12);
    applyStimulus(0, 1'b0, 5, -2);
    checkOutput("acc_5xm2", regS, 32'd2);
    applyStimulus(0, 1'b0, -7, -1);
    checkOutput("acc_m7xm1", regS, 32'd9);

    // Signed extremes
    applyStimulus(0, 1'b1, 0, 0);
    applyStimulus(0, 1'b0, -128, -128);
    checkOutput("ext_m128xm128", regS, 32'd16384);
    applyStimulus(0, 1'b0, -128, 127);
    checkOutput("ext_m128x127", regS, 32'd128);

    // 3x3 sharpen window, unsigned pixels
    applyStimulus(1, 1'b1, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1'b0, sharpX[i], sharpY[i]);
    checkOutput("sharpen", regU, 32'd60);
    applyStimulus(1, 1'b1, 0, 0);
    applyStimulus(1, 1'b0, 255, -1);
    checkOutput("ext_255xm1", regU, 32'hFFFF_FF01);

    // Wrap past 2^31-1 using the wide instance
    applyStimulus(2, 1'b1, 0, 0);
    applyStimulus(2, 1'b0, 32767, 32767);
    applyStimulus(2, 1'b0, 32767, 32767);
    checkOutput("wide_preload", regW, 32'd2147352578);
    applyStimulus(2, 1'b0, 32767, 32767);
    checkOutput("wide_wrap", regW, 32'd3221028867);

    // Mid-sequence reset: reset wins over valid data
    applyStimulus(0, 1'b1, 0, 0);
    applyStimulus(0, 1'b0, 2, 3);
    checkOutput("mid_6", regS, 32'd6);
    applyStimulus(0, 1'b0, 2, 3);
    checkOutput("mid_12", regS, 32'd12);
    applyStimulus(0, 1'b0, 2, 3);
    checkOutput("mid_18", regS, 32'd18);
    applyStimulus(0, 1'b1, 9, 9);
    checkOutput("mid_reset", regS, 32'd0);
    applyStimulus(0, 1'b0, 1, 1);
    checkOutput("mid_resume", regS, 32'd1);

    // Held reset with nonzero data
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 50, -3);
      checkOutput("held_reset", regS, 32'd0);
    end

    // Randomized runs on randomly chosen instances with occasional resets
    for (int run = 0; run < 30; run++) begin
      which = int'($urandom_range(0, 2));
      len   = int'($urandom_range(5, 25));
      for (int k = 0; k < len; k++) begin
        rv = int'($urandom);
        applyStimulus(which, ($urandom_range(0, 15) == 0), rv, int'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
